// File: rtl/simd_mem_loader.sv
// simd_mem_loader: host-stream loader/dumper for the simd_top memory buses,
// with core reset sequencing, program-end detection and a run-cycle counter.
`timescale 1ns/1ps
module simd_mem_loader #(
  parameter int unsigned PE_NUM      = 4,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LEN_WIDTH   = 11,
  parameter int unsigned FINISH_HOLD = 4
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iCmd_Valid,
  output logic                    oCmd_Ready,
  input  logic [1:0]              iCmd_Region,
  input  logic                    iCmd_Read,
  input  logic [ADDR_WIDTH-1:0]   iCmd_Base,
  input  logic [LEN_WIDTH-1:0]    iCmd_Length,
  input  logic                    iIn_Valid,
  output logic                    oIn_Ready,
  input  logic [31:0]             iIn_Data,
  output logic                    oOut_Valid,
  input  logic                    iOut_Ready,
  output logic [31:0]             oOut_Data,
  output logic                    oBus_CP_IMEM_Valid,
  output logic                    oBus_PE_IMEM_Valid,
  output logic                    oBus_CP_DMEM_Valid,
  output logic                    oBus_PE_DMEM_Valid,
  output logic                    oBus_Write_Enable,
  output logic [ADDR_WIDTH-1:0]   oBus_Address,
  output logic [32*PE_NUM-1:0]    oBus_Write_Data,
  input  logic [31:0]             iBus_CP_IMEM_Read_Data,
  input  logic [31:0]             iBus_PE_IMEM_Read_Data,
  input  logic [31:0]             iBus_CP_DMEM_Read_Data,
  input  logic [32*PE_NUM-1:0]    iBus_PE_DMEM_Read_Data,
  input  logic                    iRun,
  input  logic [ADDR_WIDTH-1:0]   iPC,
  input  logic                    iTask_Finished,
  output logic                    oCore_Reset,
  output logic                    oDone,
  output logic [31:0]             oCycle_Count
);

  localparam int unsigned DATA_W = 32 * PE_NUM;
  localparam int unsigned LANE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int unsigned HOLD_W = (FINISH_HOLD > 0) ? $clog2(FINISH_HOLD + 1) : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PE_NUM - 1);
  localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(FINISH_HOLD);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_SEND, RUN} state_e;
  typedef enum logic [1:0] {REG_CP_IMEM, REG_PE_IMEM, REG_CP_DMEM, REG_PE_DMEM} region_e;

  state_e                state_q, state_d;
  region_e               region_q, region_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_W-1:0]     pack_q, pack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [3:0]            wr_strobe_q, wr_strobe_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [ADDR_WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic                  pc_valid_q, pc_valid_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  advance;
  logic [3:0]            rd_strobe;

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    rdata_d      = rdata_q;
    wr_strobe_d  = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    cycle_d      = cycle_q;
    pc_prev_d    = iPC;
    pc_valid_d   = 1'b0;
    hold_d       = '0;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        if (iRun) begin
          state_d      = RUN;
          core_reset_d = 1'b0;
          done_d       = 1'b0;
          cycle_d      = '0;
        end else if (cmd_ready_q && iCmd_Valid) begin
          region_d = region_e'(iCmd_Region);
          addr_d   = iCmd_Base;
          remain_d = iCmd_Length;
          lane_d   = '0;
          if (iCmd_Length != '0) begin
            state_d = iCmd_Read ? RD_ISSUE : LOAD;
          end
        end
      end

      LOAD: begin
        if (iIn_Valid) begin
          if (region_q == REG_PE_DMEM) begin
            pack_d[32*lane_q +: 32] = iIn_Data;
            if (lane_q == LAST_LANE) begin
              wr_strobe_d[REG_PE_DMEM] = 1'b1;
              wr_data_d                = pack_d;
              lane_d                   = '0;
              advance                  = 1'b1;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end else begin
            wr_strobe_d[region_q] = 1'b1;
            wr_data_d             = DATA_W'(iIn_Data);
            advance               = 1'b1;
          end
          if (advance) begin
            wr_addr_d = addr_q;
            addr_d    = addr_q + 1'b1;
            remain_d  = remain_q - 1'b1;
            if (remain_q == LEN_ONE) begin
              state_d = IDLE;
            end
          end
        end
      end

      RD_ISSUE: state_d = RD_WAIT;

      RD_WAIT: begin
        case (region_q)
          REG_CP_IMEM: rdata_d = DATA_W'(iBus_CP_IMEM_Read_Data);
          REG_PE_IMEM: rdata_d = DATA_W'(iBus_PE_IMEM_Read_Data);
          REG_CP_DMEM: rdata_d = DATA_W'(iBus_CP_DMEM_Read_Data);
          default:     rdata_d = iBus_PE_DMEM_Read_Data;
        endcase
        lane_d  = '0;
        state_d = RD_SEND;
      end

      RD_SEND: begin
        if (iOut_Ready) begin
          if (region_q == REG_PE_DMEM && lane_q != LAST_LANE) begin
            lane_d = lane_q + 1'b1;
          end else begin
            lane_d   = '0;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            state_d  = (remain_q == LEN_ONE) ? IDLE : RD_ISSUE;
          end
        end
      end

      RUN: begin
        if (cycle_q != '1) begin
          cycle_d = cycle_q + 1'b1;
        end
        // The first RUN cycle has no valid previous PC, so it never counts as a repeat;
        // a full hold count is acted on the cycle after it is reached.
        pc_valid_d = 1'b1;
        if (pc_valid_q && iPC == pc_prev_q) begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        if (iTask_Finished || hold_q == HOLD_MAX) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          core_reset_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q      <= IDLE;
      region_q     <= REG_CP_IMEM;
      addr_q       <= '0;
      remain_q     <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      rdata_q      <= '0;
      wr_strobe_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cmd_ready_q  <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      cycle_q      <= '0;
      pc_prev_q    <= '0;
      pc_valid_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      rdata_q      <= rdata_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cmd_ready_q  <= cmd_ready_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      cycle_q      <= cycle_d;
      pc_prev_q    <= pc_prev_d;
      pc_valid_q   <= pc_valid_d;
      hold_q       <= hold_d;
    end
  end

  // Writes leave registered one cycle after the handshake; reads strobe during RD_ISSUE.
  assign rd_strobe = (state_q == RD_ISSUE) ? (4'b0001 << region_q) : 4'b0000;

  assign oBus_CP_IMEM_Valid = wr_strobe_q[REG_CP_IMEM] | rd_strobe[REG_CP_IMEM];
  assign oBus_PE_IMEM_Valid = wr_strobe_q[REG_PE_IMEM] | rd_strobe[REG_PE_IMEM];
  assign oBus_CP_DMEM_Valid = wr_strobe_q[REG_CP_DMEM] | rd_strobe[REG_CP_DMEM];
  assign oBus_PE_DMEM_Valid = wr_strobe_q[REG_PE_DMEM] | rd_strobe[REG_PE_DMEM];
  assign oBus_Write_Enable  = |wr_strobe_q;
  assign oBus_Address       = (state_q == RD_ISSUE) ? addr_q : wr_addr_q;
  assign oBus_Write_Data    = wr_data_q;

  assign oCmd_Ready   = cmd_ready_q;
  assign oIn_Ready    = (state_q == LOAD);
  assign oOut_Valid   = (state_q == RD_SEND);
  assign oOut_Data    = rdata_q[32*lane_q +: 32];
  assign oCore_Reset  = core_reset_q;
  assign oDone        = done_q;
  assign oCycle_Count = cycle_q;

endmodule
